// File: rtl/sprite_mover.sv
// sprite_mover: per-frame sprite position controller.
// Samples a {up,down,left,right} pad on every frame_tick and moves a registered
// {x,y} position. A held direction moves at STEP_SLOW first and switches to
// STEP_FAST after ACCEL_TICKS ticks. The position is clamped to the playfield.
// When SPRITE_MOVER_WRAP_EN is defined, the playfield wraps around instead.
// A load strobe respawns the sprite at {load_x,load_y}.
// Screen convention: up decreases y, left decreases x.

module sprite_mover #(
  parameter int COORD_W     = 10,
  parameter int START_X     = 263,
  parameter int START_Y     = 170,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 629,
  parameter int Y_MIN       = 0,
  parameter int Y_MAX       = 469,
  parameter int STEP_SLOW   = 5,
  parameter int STEP_FAST   = 10,
  parameter int ACCEL_TICKS = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_tick,
  input  logic [3:0]             dir,
  input  logic                   load,
  input  logic [COORD_W-1:0]     load_x,
  input  logic [COORD_W-1:0]     load_y,
  output logic [2*COORD_W-1:0]   position,
  output logic                   moving,
  output logic                   fast,
  output logic [3:0]             edge_hit
);

  // Coordinate arithmetic uses two extra bits. This leaves room for coord+step
  // and coord+span, so the bound comparisons never overflow or underflow.
  localparam int EW    = COORD_W + 2;
  localparam int CNT_W = $clog2(ACCEL_TICKS + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SLOW = 2'd1;
  localparam logic [1:0] S_FAST = 2'd2;

  localparam logic [EW-1:0] L_X_MIN = EW'(X_MIN);
  localparam logic [EW-1:0] L_X_MAX = EW'(X_MAX);
  localparam logic [EW-1:0] L_Y_MIN = EW'(Y_MIN);
  localparam logic [EW-1:0] L_Y_MAX = EW'(Y_MAX);

  // Bit positions inside the {up,down,left,right} vectors.
  localparam int B_UP    = 3;
  localparam int B_DOWN  = 2;
  localparam int B_LEFT  = 1;
  localparam int B_RIGHT = 0;

  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [3:0]         r_prev;
  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic [3:0]         r_edge;

  logic [3:0]         w_eff;
  logic [1:0]         w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_move;
  logic [EW-1:0]      w_step;
  logic [COORD_W-1:0] w_x_nxt;
  logic [COORD_W-1:0] w_y_nxt;
  logic [3:0]         w_edge_nxt;

  // Moves one axis by step in the requested direction. It returns the new
  // coordinate and flags which side hit the playfield boundary.
  function automatic void f_axis(
    input  logic [EW-1:0]      coord,
    input  logic               dec,
    input  logic               inc,
    input  logic [EW-1:0]      step,
    input  logic [EW-1:0]      lo,
    input  logic [EW-1:0]      hi,
    output logic [COORD_W-1:0] new_coord,
    output logic               hit_dec,
    output logic               hit_inc
  );
`ifdef SPRITE_MOVER_WRAP_EN
    logic [EW-1:0] span;
    span = hi - lo + EW'(1);
`endif
    new_coord = coord[COORD_W-1:0];
    hit_dec   = 1'b0;
    hit_inc   = 1'b0;
    if (dec) begin
      if (coord < lo + step) begin
`ifdef SPRITE_MOVER_WRAP_EN
        new_coord = COORD_W'(coord + span - step);
`else
        new_coord = COORD_W'(lo);
`endif
        hit_dec = 1'b1;
      end else begin
        new_coord = COORD_W'(coord - step);
      end
    end else if (inc) begin
      if (coord + step > hi) begin
`ifdef SPRITE_MOVER_WRAP_EN
        new_coord = COORD_W'(coord + step - span);
`else
        new_coord = COORD_W'(hi);
`endif
        hit_inc = 1'b1;
      end else begin
        new_coord = COORD_W'(coord + step);
      end
    end
  endfunction

  // Effective direction: pressing both keys of an axis cancels that axis.
  always_comb begin
    w_eff[B_UP]    = dir[B_UP]    & ~dir[B_DOWN];
    w_eff[B_DOWN]  = dir[B_DOWN]  & ~dir[B_UP];
    w_eff[B_LEFT]  = dir[B_LEFT]  & ~dir[B_RIGHT];
    w_eff[B_RIGHT] = dir[B_RIGHT] & ~dir[B_LEFT];
  end

  // Acceleration FSM. It decides the next state, the hold counter, and
  // whether this tick moves.
  always_comb begin
    // NOTE: every combinational output is given a default first so that no
    // path leaves it unassigned, which would otherwise infer a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_move      = 1'b0;
    if (w_eff == 4'b0000) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else if (r_state == S_IDLE || w_eff != r_prev) begin
      w_state_nxt = S_SLOW;
      w_cnt_nxt   = CNT_W'(1);
      w_move      = 1'b1;
    end else begin
      w_move = 1'b1;
      case (r_state)
        S_SLOW: begin
          if (r_cnt < CNT_W'(ACCEL_TICKS)) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end else begin
            w_state_nxt = S_FAST;
          end
        end
        S_FAST:  w_state_nxt = S_FAST;
        default: begin
          // Unreachable encoding: restart the ramp cleanly.
          w_state_nxt = S_SLOW;
          w_cnt_nxt   = CNT_W'(1);
        end
      endcase
    end
  end

  // The step size follows the state being entered, so the tick that switches
  // to FAST already moves at the fast rate.
  always_comb begin
    w_step = (w_state_nxt == S_FAST) ? EW'(STEP_FAST) : EW'(STEP_SLOW);
  end

  // Next position and boundary flags for both axes.
  always_comb begin
    w_x_nxt    = r_x;
    w_y_nxt    = r_y;
    w_edge_nxt = 4'b0000;
    f_axis(EW'(r_x), w_move & w_eff[B_LEFT], w_move & w_eff[B_RIGHT],
           w_step, L_X_MIN, L_X_MAX,
           w_x_nxt, w_edge_nxt[B_LEFT], w_edge_nxt[B_RIGHT]);
    f_axis(EW'(r_y), w_move & w_eff[B_UP], w_move & w_eff[B_DOWN],
           w_step, L_Y_MIN, L_Y_MAX,
           w_y_nxt, w_edge_nxt[B_UP], w_edge_nxt[B_DOWN]);
  end

  // State register. Priority: reset, then respawn load, then frame tick.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_prev  <= 4'b0000;
      r_x     <= COORD_W'(START_X);
      r_y     <= COORD_W'(START_Y);
      r_edge  <= 4'b0000;
    end else if (load) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_prev  <= 4'b0000;
      r_x     <= load_x;
      r_y     <= load_y;
      r_edge  <= 4'b0000;
    end else if (frame_tick) begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_prev  <= w_eff;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_edge  <= w_edge_nxt;
    end
  end

  // Outputs come straight from registers or from decoded state bits.
  always_comb begin
    position = {r_x, r_y};
    moving   = (r_state == S_SLOW) || (r_state == S_FAST);
    fast     = (r_state == S_FAST);
    edge_hit = r_edge;
  end

endmodule

// File: tb/tb_sprite_mover.sv
// Directed testbench for sprite_mover (default parameters).
// Expected values are hand-computed. Wrap-specific expectations are selected
// with SPRITE_MOVER_WRAP_EN, matching the RTL build.

module tb_sprite_mover;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_tick;
  logic [3:0]  dir;
  logic        load;
  logic [9:0]  load_x;
  logic [9:0]  load_y;
  logic [19:0] position;
  logic        moving;
  logic        fast;
  logic [3:0]  edge_hit;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  sprite_mover dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .dir        (dir),
    .load       (load),
    .load_x     (load_x),
    .load_y     (load_y),
    .position   (position),
    .moving     (moving),
    .fast       (fast),
    .edge_hit   (edge_hit)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [31:0] pos(input int x, input int y);
    return 32'((x << 10) | y);
  endfunction

  // One clock of stimulus. Inputs change on the falling edge, and outputs
  // are valid 1 ns after the rising edge.
  task automatic drive(input logic tk, input logic [3:0] d, input logic ld,
                       input logic [9:0] lx, input logic [9:0] ly);
    @(negedge clk);
    frame_tick = tk;
    dir        = d;
    load       = ld;
    load_x     = lx;
    load_y     = ly;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    load       = 1'b0;
  endtask

  task automatic tick(input logic [3:0] d);
    drive(1'b1, d, 1'b0, 10'd0, 10'd0);
  endtask

  task automatic do_load(input int x, input int y);
    drive(1'b0, 4'b0000, 1'b1, 10'(x), 10'(y));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_x [10];
    exp_x = '{268, 273, 278, 283, 288, 293, 298, 303, 313, 323};

    rst_n = 1'b1; frame_tick = 1'b0; dir = 4'b0000; load = 1'b0;
    load_x = '0; load_y = '0;

    // Reset overrides tick and load on the same edge.
    @(negedge clk);
    rst_n = 1'b0; frame_tick = 1'b1; dir = 4'b0001; load = 1'b1;
    load_x = 10'd50; load_y = 10'd60;
    @(posedge clk);
    #1;
    rst_n = 1'b1; frame_tick = 1'b0; load = 1'b0; dir = 4'b0000;
    check("reset_pos",    position, pos(263, 170));
    check("reset_moving", moving,   0);
    check("reset_fast",   fast,     0);
    check("reset_edge",   edge_hit, 0);

    // Acceleration: 8 slow ticks, then fast.
    for (int i = 0; i < 10; i++) begin
      tick(4'b0001);
      check($sformatf("accel_pos_%0d", i + 1),  position, pos(exp_x[i], 170));
      check($sformatf("accel_fast_%0d", i + 1), fast,     (i >= 8) ? 1 : 0);
      check($sformatf("accel_mov_%0d", i + 1),  moving,   1);
    end

    // A direction change while FAST restarts the slow ramp.
    tick(4'b0101);
    check("chg_pos",  position, pos(328, 175));
    check("chg_fast", fast,     0);
    check("chg_mov",  moving,   1);

    // Opposite keys cancel out.
    for (int i = 0; i < 3; i++) begin
      tick(4'b1100);
      check($sformatf("cancel_pos_%0d", i), position, pos(328, 175));
      check($sformatf("cancel_mov_%0d", i), moving,   0);
    end

    // Diagonal move near the top-left corner.
    do_load(3, 2);
    check("ld32_pos", position, pos(3, 2));
    check("ld32_mov", moving,   0);
    tick(4'b1010);
`ifdef SPRITE_MOVER_WRAP_EN
    check("diag_pos", position, pos(628, 467));
`else
    check("diag_pos", position, pos(0, 0));
`endif
    check("diag_edge", edge_hit, 4'b1010);
    tick(4'b0000);
    check("idle_edge", edge_hit, 0);
    check("idle_mov",  moving,   0);

    // Exactly reaching MAX is not a clamp; going past it is.
    do_load(624, 464);
    tick(4'b0101);
    check("max_exact_pos",  position, pos(629, 469));
    check("max_exact_edge", edge_hit, 0);
    tick(4'b0101);
`ifdef SPRITE_MOVER_WRAP_EN
    check("max_over_pos", position, pos(4, 4));
`else
    check("max_over_pos", position, pos(629, 469));
`endif
    check("max_over_edge", edge_hit, 4'b0101);

    // Exactly reaching MIN is not a clamp.
    do_load(5, 5);
    tick(4'b1010);
    check("min_exact_pos",  position, pos(0, 0));
    check("min_exact_edge", edge_hit, 0);

    // Reach FAST at {400,300}, then load together with a tick.
    do_load(350, 300);
    for (int i = 0; i < 9; i++) tick(4'b0001);
    check("pre_ld_pos",  position, pos(400, 300));
    check("pre_ld_fast", fast,     1);
    drive(1'b1, 4'b0001, 1'b1, 10'd50, 10'd60);
    check("ldtick_pos",  position, pos(50, 60));
    check("ldtick_mov",  moving,   0);
    check("ldtick_fast", fast,     0);
    check("ldtick_edge", edge_hit, 0);

    // dir is ignored between ticks.
    @(negedge clk);
    dir = 4'b0001;
    repeat (3) @(posedge clk);
    #1;
    check("notick_pos", position, pos(50, 60));
    check("notick_mov", moving,   0);

    tick(4'b0001);
    check("after_ld_pos",  position, pos(55, 60));
    check("after_ld_fast", fast,     0);
    for (int i = 0; i < 8; i++) tick(4'b0001);
    check("fast2_pos",  position, pos(100, 60));
    check("fast2_fast", fast,     1);

    // Reset while FAST.
    @(negedge clk);
    rst_n = 1'b0; frame_tick = 1'b1; dir = 4'b0001;
    @(posedge clk);
    #1;
    rst_n = 1'b1; frame_tick = 1'b0;
    check("rstfast_pos",  position, pos(263, 170));
    check("rstfast_mov",  moving,   0);
    check("rstfast_fast", fast,     0);
    tick(4'b0001);
    check("rstfast_tick_pos",  position, pos(268, 170));
    check("rstfast_tick_fast", fast,     0);

    // Right and up boundary single-axis moves.
    do_load(627, 100);
    tick(4'b0001);
`ifdef SPRITE_MOVER_WRAP_EN
    check("right_edge_pos", position, pos(2, 100));
`else
    check("right_edge_pos", position, pos(629, 100));
`endif
    check("right_edge_bit", edge_hit, 4'b0001);
    do_load(2, 1);
    tick(4'b1000);
`ifdef SPRITE_MOVER_WRAP_EN
    check("up_edge_pos", position, pos(2, 466));
`else
    check("up_edge_pos", position, pos(2, 0));
`endif
    check("up_edge_bit", edge_hit, 4'b1000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
